// File: rtl/operand2_issue_pkg.sv
// Shared definitions for the operand2 issue unit: word width, barrel shifter type codes,
// FSM state encoding, ARM data-processing instruction field offsets and the operand bundle.
package operand2_issue_pkg;

  localparam int WordWidth = 32;

  localparam logic [1:0] LogicalLeftShift     = 2'b00;
  localparam logic [1:0] LogicalRightShift    = 2'b01;
  localparam logic [1:0] ArithmeticRightShift = 2'b10;
  localparam logic [1:0] RotateRightShift     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_RS  = 3'd1,
    ST_RD_RM  = 3'd2,
    ST_CAP_RM = 3'd3,
    ST_ISSUE  = 3'd4
  } state_e;

  localparam int ImmBit      = 25;
  localparam int RegShiftBit = 4;
  localparam int RmLsb       = 0;
  localparam int ShTypeLsb   = 5;
  localparam int ShImmLsb    = 7;
  localparam int RsLsb       = 8;
  localparam int RotLsb      = 8;
  localparam int Imm8Lsb     = 0;

  typedef struct packed {
    logic [WordWidth-1:0] reg_val;
    logic [WordWidth-1:0] imm_val;
    logic [3:0]           rotate;
    logic [4:0]           shift_val;
    logic [1:0]           shift_type;
    logic                 imm_sel;
    logic                 override;
    logic [WordWidth-1:0] override_val;
    logic                 override_carry;
  } bundle_t;

  function automatic logic [WordWidth-1:0] zext_imm8(input logic [7:0] imm8);
    return {{(WordWidth-8){1'b0}}, imm8};
  endfunction

endpackage

// File: rtl/reg_shift_resolve.sv
// Maps a register-specified shift (8-bit amount) onto the 5-bit barrel shifter, forcing the
// operand and carry where the shifter cannot express the result. Purely combinational.
module reg_shift_resolve
  import operand2_issue_pkg::*;
(
  input  logic [WordWidth-1:0] rm_i,
  input  logic [7:0]           amt_i,
  input  logic [1:0]           type_i,
  output logic [4:0]           shift_val_o,
  output logic [1:0]           shift_type_o,
  output logic                 override_o,
  output logic [WordWidth-1:0] override_val_o,
  output logic                 override_carry_o
);

  logic amt_zero;
  logic amt_big;
  logic amt_is_32;

  assign amt_zero  = (amt_i == 8'd0);
  assign amt_big   = |amt_i[7:5];
  assign amt_is_32 = (amt_i == 8'd32);

  always_comb begin
    shift_val_o      = amt_i[4:0];
    shift_type_o     = type_i;
    override_o       = 1'b0;
    override_val_o   = '0;
    override_carry_o = 1'b0;
    if (amt_zero) begin
      // Zero amount leaves Rm and the incoming carry untouched: LSL #0 does exactly that.
      shift_type_o = LogicalLeftShift;
    end else if (amt_big) begin
      case (type_i)
        LogicalLeftShift: begin
          override_o       = 1'b1;
          override_carry_o = amt_is_32 & rm_i[0];
        end
        LogicalRightShift: begin
          // LSR #0 in the shifter's encoding already means a 32-bit shift.
          override_o = ~amt_is_32;
        end
        ArithmeticRightShift: begin
          shift_val_o = 5'd0;
        end
        default: begin
          if (amt_i[4:0] == 5'd0) begin
            override_o       = 1'b1;
            override_val_o   = rm_i;
            override_carry_o = rm_i[WordWidth-1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/operand2_issue.sv
// Decodes ARM operand2, sequences Rs/Rm register reads and issues one registered operand bundle.
// Latency imm/shift-imm/shift-reg = 1/3/4 cycles; bundle held until in_Ready, out_Ready only in IDLE.
module operand2_issue
  import operand2_issue_pkg::*;
(
  input  logic                 in_Clk,
  input  logic                 in_Reset_n,
  input  logic                 in_Valid,
  input  logic [31:0]          in_Instr,
  output logic                 out_Ready,
  output logic [3:0]           out_Rf_addr,
  input  logic [WordWidth-1:0] in_Rf_data,
  output logic                 out_Valid,
  input  logic                 in_Ready,
  output logic [WordWidth-1:0] out_Reg_val,
  output logic [WordWidth-1:0] out_Imm_val,
  output logic [3:0]           out_Rotate,
  output logic [4:0]           out_Shift_val,
  output logic [1:0]           out_Shift_type,
  output logic                 out_Imm_sel,
  output logic                 out_Override,
  output logic [WordWidth-1:0] out_Override_val,
  output logic                 out_Override_carry
);

  state_e         state_q, state_d;
  logic [11:0]    instr_q, instr_d;
  logic [7:0]     amt_q, amt_d;
  bundle_t        bundle_q, bundle_d;

  logic           accept;
  logic           latch_amt;
  logic           load_rm;
  logic           done;

  logic [4:0]           rs_shift_val;
  logic [1:0]           rs_shift_type;
  logic                 rs_override;
  logic [WordWidth-1:0] rs_override_val;
  logic                 rs_override_carry;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{in_Instr[31:26], in_Instr[24:12]};

  always_ff @(posedge in_Clk or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_Ready   = 1'b0;
    out_Valid   = 1'b0;
    out_Rf_addr = 4'd0;
    accept      = 1'b0;
    latch_amt   = 1'b0;
    load_rm     = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_Ready = 1'b1;
        if (in_Valid) begin
          accept = 1'b1;
          if (in_Instr[ImmBit]) begin
            state_d = ST_ISSUE;
          end else if (in_Instr[RegShiftBit]) begin
            state_d = ST_RD_RS;
          end else begin
            state_d = ST_RD_RM;
          end
        end
      end
      ST_RD_RS: begin
        out_Rf_addr = instr_q[RsLsb +: 4];
        state_d     = ST_RD_RM;
      end
      ST_RD_RM: begin
        // Read data now on in_Rf_data is Rs when arriving from RD_RS.
        out_Rf_addr = instr_q[RmLsb +: 4];
        latch_amt   = instr_q[RegShiftBit];
        state_d     = ST_CAP_RM;
      end
      ST_CAP_RM: begin
        load_rm = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        out_Valid = 1'b1;
        if (in_Ready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  reg_shift_resolve u_resolve (
    .rm_i             (in_Rf_data),
    .amt_i            (amt_q),
    .type_i           (instr_q[ShTypeLsb +: 2]),
    .shift_val_o      (rs_shift_val),
    .shift_type_o     (rs_shift_type),
    .override_o       (rs_override),
    .override_val_o   (rs_override_val),
    .override_carry_o (rs_override_carry)
  );

  assign instr_d = accept ? in_Instr[11:0] : instr_q;
  assign amt_d   = latch_amt ? in_Rf_data[7:0] : amt_q;

  always_comb begin
    bundle_d = bundle_q;
    if (accept && in_Instr[ImmBit]) begin
      bundle_d         = '0;
      bundle_d.imm_val = zext_imm8(in_Instr[Imm8Lsb +: 8]);
      bundle_d.rotate  = in_Instr[RotLsb +: 4];
      bundle_d.imm_sel = 1'b1;
    end else if (load_rm) begin
      bundle_d         = '0;
      bundle_d.reg_val = in_Rf_data;
      bundle_d.imm_val = zext_imm8(instr_q[Imm8Lsb +: 8]);
      bundle_d.rotate  = instr_q[RotLsb +: 4];
      if (instr_q[RegShiftBit]) begin
        bundle_d.shift_val      = rs_shift_val;
        bundle_d.shift_type     = rs_shift_type;
        bundle_d.override       = rs_override;
        bundle_d.override_val   = rs_override_val;
        bundle_d.override_carry = rs_override_carry;
      end else begin
        // Immediate-amount #0 encodings go to the shifter as-is; it owns their meaning.
        bundle_d.shift_val  = instr_q[ShImmLsb +: 5];
        bundle_d.shift_type = instr_q[ShTypeLsb +: 2];
      end
    end else if (done) begin
      bundle_d = '0;
    end
  end

  always_ff @(posedge in_Clk or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      instr_q  <= '0;
      amt_q    <= '0;
      bundle_q <= '0;
    end else begin
      instr_q  <= instr_d;
      amt_q    <= amt_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_Reg_val        = bundle_q.reg_val;
  assign out_Imm_val        = bundle_q.imm_val;
  assign out_Rotate         = bundle_q.rotate;
  assign out_Shift_val      = bundle_q.shift_val;
  assign out_Shift_type     = bundle_q.shift_type;
  assign out_Imm_sel        = bundle_q.imm_sel;
  assign out_Override       = bundle_q.override;
  assign out_Override_val   = bundle_q.override_val;
  assign out_Override_carry = bundle_q.override_carry;

endmodule
